// File: rtl/window_gen_3x3.sv
// Raster-order 3x3 window generator for the PE: one 72-bit window per accepted pixel once row>=2 and col>=2.
// Output is registered on the accept edge; there is no backpressure, so a window must be taken whenever win_en=1.
module window_gen_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_en,
  output logic [71:0] win_out,
  output logic        win_en,
  output logic        frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic [7:0] r_lb0 [IMG_W];
  logic [7:0] r_lb1 [IMG_W];

  // Only the two older columns are stored; the newest column is the live
  // {LB0[col], LB1[col], pix_in} slice, which keeps the output one stage deep.
  logic [7:0] r_win [3][2];

  logic        w_last_col;
  logic        w_last_row;
  logic        w_win_ok;
  logic        w_accept;
  logic [7:0]  w_new_col [3];
  logic [71:0] w_win;

  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_accept   = pix_en && !reset;

  always_comb begin
    w_new_col[0] = r_lb0[r_col];
    w_new_col[1] = r_lb1[r_col];
    w_new_col[2] = pix_in;
  end

  always_comb begin
    w_win = {r_win[0][0], r_win[0][1], w_new_col[0],
             r_win[1][0], r_win[1][1], w_new_col[1],
             r_win[2][0], r_win[2][1], w_new_col[2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_en) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers and window columns carry no reset; stale contents are masked by the row gate.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_in;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_out    <= '0;
      win_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_en     <= pix_en && w_win_ok;
      frame_done <= pix_en && w_win_ok && w_last_row && w_last_col;
      if (pix_en && w_win_ok) begin
        win_out <= w_win;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: an 8x8 instance driven through several frame patterns and a 3x3 instance.
module tb_window_gen_3x3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pix_en;
  logic [7:0]  pix_in;
  logic [71:0] win_out;
  logic        win_en, frame_done;

  logic        reset3, pix_en3;
  logic [7:0]  pix_in3;
  logic [71:0] win_out3;
  logic        win_en3, frame_done3;

  window_gen_3x3 #(.IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_en(pix_en),
    .win_out(win_out), .win_en(win_en), .frame_done(frame_done)
  );

  window_gen_3x3 #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .reset(reset3), .pix_in(pix_in3), .pix_en(pix_en3),
    .win_out(win_out3), .win_en(win_en3), .frame_done(frame_done3)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [72:0] exp_q [$];
  logic [71:0] got_wins [$];
  logic [7:0]  img [8][8];
  int          m_row, m_col;
  int          fd_cnt;
  logic        exp_en;
  logic [71:0] last_win;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic en, input logic [7:0] px, input logic rst);
    logic [71:0] w;
    logic [72:0] e;
    reset  = rst;
    pix_en = en;
    pix_in = px;
    exp_en = 1'b0;
    if (rst) begin
      m_row = 0;
      m_col = 0;
      last_win = '0;
      exp_q.delete();
    end else if (en) begin
      img[m_row][m_col] = px;
      if (m_row >= 2 && m_col >= 2) begin
        w = '0;
        for (int rr = m_row - 2; rr <= m_row; rr++)
          for (int cc = m_col - 2; cc <= m_col; cc++)
            w = {w[63:0], img[rr][cc]};
        exp_q.push_back({(m_row == 7 && m_col == 7), w});
        exp_en = 1'b1;
      end
      if (m_col == 7) begin
        m_col = 0;
        m_row = (m_row == 7) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    chk("win_en", win_en, exp_en);
    if (win_en) begin
      chk("queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("win_out", win_out, e[71:0]);
        chk("frame_done", frame_done, e[72]);
        last_win = e[71:0];
      end
      got_wins.push_back(win_out);
      if (frame_done) fd_cnt++;
    end else begin
      chk("win_hold", win_out, last_win);
      chk("frame_done_idle", frame_done, 1'b0);
      exp_q.delete();
    end
  endtask

  task automatic new_test();
    got_wins.delete();
    fd_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; pix_in = '0;
    reset3 = 1'b1; pix_en3 = 1'b0; pix_in3 = '0;
    last_win = '0; m_row = 0; m_col = 0; fd_cnt = 0;

    // reset state
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // single frame, pix_en held high
    new_test();
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t1_count", got_wins.size(), 36);
    chk("t1_fd_count", fd_cnt, 1);
    if (got_wins.size() > 0) begin
      chk("t1_first", got_wins[0], 72'h000102_08090A_101112);
      chk("t1_last", got_wins[got_wins.size() - 1], 72'h2D2E2F_353637_3D3E3F);
    end

    // pix_en toggled 1,0,0,1,...
    new_test();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    end
    chk("t2_count", got_wins.size(), 36);
    chk("t2_fd_count", fd_cnt, 1);
    if (got_wins.size() > 0) begin
      chk("t2_first", got_wins[0], 72'h000102_08090A_101112);
      chk("t2_last", got_wins[got_wins.size() - 1], 72'h2D2E2F_353637_3D3E3F);
    end

    // two back-to-back frames
    new_test();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i + 64 * f), 1'b0);
    chk("t3_count", got_wins.size(), 72);
    chk("t3_fd_count", fd_cnt, 2);
    if (got_wins.size() > 36)
      chk("t3_frame2_first", got_wins[36], 72'h404142_48494A_505152);

    // reset after 30 pixels (with pix_en high on the reset edge), then a full frame
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    new_test();
    cycle(1'b1, 8'hFF, 1'b1);
    chk("t4_reset_out", win_out, 72'h0);
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i) ^ 8'h5A, 1'b0);
    chk("t4_count", got_wins.size(), 36);
    chk("t4_fd_count", fd_cnt, 1);

    // 3x3 frame
    reset3 = 1'b1; pix_en3 = 1'b0; pix_in3 = '0;
    @(posedge clk); #1;
    chk("w3_reset_en", win_en3, 1'b0);
    chk("w3_reset_out", win_out3, 72'h0);
    reset3 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      pix_en3 = 1'b1;
      pix_in3 = 8'(i);
      @(posedge clk); #1;
      chk("w3_en", win_en3, (i == 9));
      chk("w3_fd", frame_done3, (i == 9));
    end
    chk("w3_out", win_out3, 72'h010203_040506_070809);
    pix_en3 = 1'b0;
    @(posedge clk); #1;
    chk("w3_idle_en", win_en3, 1'b0);
    chk("w3_idle_fd", frame_done3, 1'b0);
    chk("w3_hold", win_out3, 72'h010203_040506_070809);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
